ddr3_req_arbiter: RTL

Merges the separate write-request and read-request ports produced by the AXI-to-memory front-end into one ordered command stream for the DDR3 command scheduler. One request is accepted per cycle, so each order-ID issued by the front-end maps to exactly one command. Arbitration favours staying in the current direction to cut bus turnarounds, with a bounded run length and a same-burst write-before-read hazard rule. It sits directly downstream of the AXI front-end's `mem_wrreq`/`mem_rdreq` ports and upstream of the DDR3 command FSM.

---
 rtl/ddr3_req_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/ddr3_req_arbiter.sv
// Merges the front-end write and read request ports into one ordered DDR3 command stream.
// Prefers the current direction up to MAX_RUN grants and never lets a read pass a same-burst write.
module ddr3_req_arbiter #(
   parameter int ADDRS     = 32,
   parameter int REQID     = 4,
   parameter int BURST_LSB = 4,
   parameter int MAX_RUN   = 4
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             mem_wrreq_i,
   output logic                             mem_wrack_o,
   input  logic [REQID-1:0]                 mem_wrtid_i,
   input  logic [ADDRS-1:0]                 mem_wradr_i,
   input  logic                             mem_rdreq_i,
   output logic                             mem_rdack_o,
   input  logic [REQID-1:0]                 mem_rdtid_i,
   input  logic [ADDRS-1:0]                 mem_rdadr_i,
   output logic                             cmd_valid_o,
   input  logic                             cmd_ready_i,
   output logic                             cmd_write_o,
   output logic [REQID-1:0]                 cmd_tid_o,
   output logic [ADDRS-1:0]                 cmd_addr_o,
   output logic                             dbg_dir,
   output logic [$clog2(MAX_RUN+1)-1:0]     dbg_run
);

   localparam int RUNW = $clog2(MAX_RUN + 1);
   localparam logic [RUNW-1:0] RUN_LIMIT = RUNW'(MAX_RUN);

   typedef enum logic {
      DIR_RD = 1'b0,
      DIR_WR = 1'b1
   } dir_t;

   dir_t            dir;
   logic [RUNW-1:0] run;
   logic            slot;
   logic            hazard;
   logic            grant_wr;
   logic            grant_rd;
   dir_t            grant_dir;

   // Handshake: a command moves on cmd_valid_o & cmd_ready_i; the register may
   // reload on that same edge, and a request is taken only in a cycle whose ack is 1.
   assign slot   = !cmd_valid_o || cmd_ready_i;
   assign hazard = mem_wrreq_i && mem_rdreq_i &&
                   (mem_wradr_i[ADDRS-1:BURST_LSB] == mem_rdadr_i[ADDRS-1:BURST_LSB]);

   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (reset && slot) begin
         if (mem_wrreq_i && mem_rdreq_i) begin
            if (hazard) begin
               grant_wr = 1'b1;
            end else if (run < RUN_LIMIT) begin
               grant_wr = (dir == DIR_WR);
               grant_rd = (dir == DIR_RD);
            end else begin
               grant_wr = (dir == DIR_RD);
               grant_rd = (dir == DIR_WR);
            end
         end else begin
            grant_wr = mem_wrreq_i;
            grant_rd = mem_rdreq_i;
         end
      end
   end

   assign grant_dir   = grant_wr ? DIR_WR : DIR_RD;
   assign mem_wrack_o = grant_wr;
   assign mem_rdack_o = grant_rd;
   assign dbg_dir     = (dir == DIR_WR);
   assign dbg_run     = run;

   always_ff @(posedge clock) begin
      if (!reset) begin
         cmd_valid_o <= 1'b0;
         cmd_write_o <= 1'b0;
         cmd_tid_o   <= '0;
         cmd_addr_o  <= '0;
         dir         <= DIR_RD;
         run         <= '0;
      end else if (grant_wr || grant_rd) begin
         cmd_valid_o <= 1'b1;
         cmd_write_o <= grant_wr;
         cmd_tid_o   <= grant_wr ? mem_wrtid_i : mem_rdtid_i;
         cmd_addr_o  <= grant_wr ? mem_wradr_i : mem_rdadr_i;
         if (grant_dir == dir) begin
            run <= (run == RUN_LIMIT) ? RUN_LIMIT : run + 1'b1;
         end else begin
            dir <= grant_dir;
            run <= RUNW'(1);
         end
      end else if (cmd_ready_i) begin
         cmd_valid_o <= 1'b0;
      end
   end

endmodule
